// File: rtl/fifol1_rr_merge_if.sv
// Requester/consumer bundle for the round-robin merge buffer.
// slave is the merge side, master is the environment side.
interface fifol1_rr_merge_if #(
  parameter int width = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = 1
);
  logic [NREQ-1:0]       REQ_VALID;
  logic [NREQ*width-1:0] REQ_D_IN;
  logic [NREQ-1:0]       REQ_LAST;
  logic [NREQ-1:0]       REQ_RDY;
  logic [width-1:0]      D_OUT;
  logic                  LAST_OUT;
  logic [IDW-1:0]        SRC_OUT;
  logic                  EMPTY_N;
  logic                  DEQ;

  modport slave (
    input  REQ_VALID, REQ_D_IN, REQ_LAST, DEQ,
    output REQ_RDY, D_OUT, LAST_OUT, SRC_OUT, EMPTY_N
  );

  modport master (
    output REQ_VALID, REQ_D_IN, REQ_LAST, DEQ,
    input  REQ_RDY, D_OUT, LAST_OUT, SRC_OUT, EMPTY_N
  );
endinterface

// File: rtl/fifol1_rr_merge.sv
// Round-robin merge of NREQ word streams into one depth-1 buffer.
// Grant is held by a requester until it sends a LAST word.
module fifol1_rr_merge #(
  parameter int width = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = 1
) (
  input logic CLK,
  input logic RST,
  input logic CLR,
  fifol1_rr_merge_if.slave bus
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   owner;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   nxt;
  logic [IDW-1:0]   src_q;
  logic             found;
  logic             slot_free;
  logic             xfer;
  logic             last_q;
  logic             empty_n_q;
  logic             word_last;
  logic [NREQ-1:0]  rdy;
  logic [width-1:0] d_q;
  logic [width-1:0] word;

  // buffer can take a word if empty or drained this cycle
  assign slot_free = !empty_n_q || bus.DEQ;

  // rotating priority scan: first valid requester from ptr
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && bus.REQ_VALID[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // grant: scan winner when idle, owner only when locked
  always_comb begin
    rdy = '0;
    sel = win;
    unique case (state)
      LOCKED: sel = owner;
      default: sel = win;
    endcase
    if (!RST && !CLR) begin
      unique case (state)
        LOCKED: rdy[owner] = slot_free && bus.REQ_VALID[owner];
        default: if (found) rdy[win] = slot_free;
      endcase
    end
  end

  assign xfer      = |rdy;
  assign word      = bus.REQ_D_IN[int'(sel)*width +: width];
  assign word_last = bus.REQ_LAST[sel];
  assign nxt       = (int'(sel) == NREQ-1) ? '0 : sel + IDW'(1);

  // buffer fill/drain and arbiter state
  always_ff @(posedge CLK) begin
    if (RST) begin
      empty_n_q <= 1'b0;
      d_q       <= '0;
      last_q    <= 1'b0;
      src_q     <= '0;
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
    end else if (CLR) begin
      empty_n_q <= 1'b0;
      state     <= IDLE;
      ptr       <= '0;
    end else if (xfer) begin
      d_q       <= word;
      last_q    <= word_last;
      src_q     <= sel;
      empty_n_q <= 1'b1;
      if (word_last) begin
        state <= IDLE;
        ptr   <= nxt;
      end else begin
        state <= LOCKED;
        owner <= sel;
      end
    end else if (bus.DEQ) begin
      empty_n_q <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // flag consumer misuse: dequeue of an empty buffer
  always_ff @(posedge CLK) begin
    if (!RST && bus.DEQ && !empty_n_q)
      $warning("fifol1_rr_merge: DEQ on empty buffer ignored");
  end
`endif

  assign bus.REQ_RDY  = rdy;
  assign bus.D_OUT    = d_q;
  assign bus.LAST_OUT = last_q;
  assign bus.SRC_OUT  = src_q;
  assign bus.EMPTY_N  = empty_n_q;
endmodule

// File: tb/tb_fifol1_rr_merge.sv
// Scoreboard bench for fifol1_rr_merge (NREQ=2).
// Expected words are queued in predicted output order.
module tb_fifol1_rr_merge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic deq = 1'b0;
  logic [1:0] en = 2'b11;
  logic [1:0] rdy;
  int ncmp = 0;
  int nerr = 0;
  int n;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [33:0] sb[$];

  fifol1_rr_merge_if #(.width(32), .NREQ(2), .IDW(1)) bus();

  fifol1_rr_merge #(.width(32), .NREQ(2), .IDW(1)) dut (
    .CLK(clk),
    .RST(rst),
    .CLR(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] w(input int r, input int m, input int k);
    return {8'hA0 | 8'(r), 8'(m), 16'(k)};
  endfunction

  task automatic feed(input int r, input logic [31:0] d, input logic l);
    if (r == 0) q0.push_back({l, d});
    else q1.push_back({l, d});
  endtask

  task automatic expect_out(input int r, input logic [31:0] d, input logic l);
    sb.push_back({1'(r), l, d});
  endtask

  task automatic put(input int r, input logic [31:0] d, input logic l);
    feed(r, d, l);
    expect_out(r, d, l);
  endtask

  task automatic cyc();
    bus.REQ_VALID[0] = en[0] && (q0.size() > 0);
    bus.REQ_VALID[1] = en[1] && (q1.size() > 0);
    bus.REQ_D_IN[31:0]  = (q0.size() > 0) ? q0[0][31:0] : 32'h0;
    bus.REQ_D_IN[63:32] = (q1.size() > 0) ? q1[0][31:0] : 32'h0;
    bus.REQ_LAST[0] = (q0.size() > 0) ? q0[0][32] : 1'b0;
    bus.REQ_LAST[1] = (q1.size() > 0) ? q1[0][32] : 1'b0;
    bus.DEQ = deq;
    @(negedge clk);
    rdy = bus.REQ_RDY;
    if (deq && bus.EMPTY_N) begin
      if (sb.size() == 0)
        chk("sb_size", sb.size(), 1);
      else
        chk("out", {bus.SRC_OUT, bus.LAST_OUT, bus.D_OUT},
            sb.pop_front());
    end
    @(posedge clk);
    #1;
    if (rdy[0]) void'(q0.pop_front());
    if (rdy[1]) void'(q1.pop_front());
  endtask

  task automatic drain(input int maxc, output int cnt);
    cnt = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0)
           && cnt < maxc) begin
      cyc();
      cnt++;
    end
    chk("drain_left", sb.size() + q0.size() + q1.size(), 0);
  endtask

  initial begin
    bus.REQ_VALID = 2'b11;
    bus.REQ_D_IN  = {w(1, 9, 9), w(0, 9, 9)};
    bus.REQ_LAST  = 2'b11;
    bus.DEQ       = 1'b0;

    // reset with all requesters valid
    @(negedge clk);
    chk("rst_rdy", bus.REQ_RDY, 0);
    chk("rst_empty", bus.EMPTY_N, 0);
    chk("rst_dout", bus.D_OUT, 0);
    chk("rst_src", bus.SRC_OUT, 0);
    chk("rst_last", bus.LAST_OUT, 0);
    @(negedge clk);
    chk("rst_rdy2", bus.REQ_RDY, 0);
    chk("rst_empty2", bus.EMPTY_N, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // first grant after reset goes to req0
    deq = 1'b1;
    put(0, w(0, 1, 0), 1'b1);
    put(1, w(1, 1, 0), 1'b1);
    cyc();
    chk("t1_first", rdy, 2'b01);
    drain(20, n);

    // fairness: alternating single-word messages
    for (int i = 0; i < 4; i++) begin
      put(0, w(0, 2, i), 1'b1);
      put(1, w(1, 2, i), 1'b1);
    end
    drain(40, n);
    chk("t2_tput", n, 9);

    // lock: 3-word message from req0 while req1 waits
    put(0, w(0, 3, 0), 1'b0);
    put(0, w(0, 3, 1), 1'b0);
    put(0, w(0, 3, 2), 1'b1);
    put(1, w(1, 3, 0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_lock", rdy, 2'b01);
    end
    drain(20, n);

    // owner drops valid mid-message: lock holds
    put(0, w(0, 4, 0), 1'b0);
    put(0, w(0, 4, 1), 1'b1);
    put(1, w(1, 4, 0), 1'b1);
    cyc();
    chk("t3b_first", rdy, 2'b01);
    en[0] = 1'b0;
    cyc();
    chk("t3b_hold1", rdy, 2'b00);
    cyc();
    chk("t3b_hold2", rdy, 2'b00);
    en[0] = 1'b1;
    cyc();
    chk("t3b_resume", rdy, 2'b01);
    drain(20, n);

    // backpressure: full buffer, no dequeue
    deq = 1'b0;
    put(0, w(0, 5, 0), 1'b1);
    put(0, w(0, 5, 1), 1'b1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_rdy", rdy, 2'b00);
      chk("t4_hold", bus.D_OUT, w(0, 5, 0));
    end
    deq = 1'b1;
    cyc();
    chk("t4_refill", rdy, 2'b01);
    drain(20, n);

    // clear while req1 is locked mid-message
    deq = 1'b0;
    feed(1, w(1, 6, 0), 1'b0);
    feed(1, w(1, 6, 1), 1'b1);
    cyc();
    chk("t5_lock", rdy, 2'b10);
    feed(0, w(0, 6, 0), 1'b1);
    clr = 1'b1;
    cyc();
    chk("t5_clr_rdy", rdy, 2'b00);
    clr = 1'b0;
    chk("t5_clr_empty", bus.EMPTY_N, 0);
    q1.push_front({1'b0, w(1, 6, 0)});
    expect_out(0, w(0, 6, 0), 1'b1);
    expect_out(1, w(1, 6, 0), 1'b0);
    expect_out(1, w(1, 6, 1), 1'b1);
    deq = 1'b1;
    cyc();
    chk("t5_next", rdy, 2'b01);
    drain(20, n);

    // dequeue of an empty buffer is ignored
    cyc();
    cyc();
    chk("t6_empty", bus.EMPTY_N, 0);
    chk("t6_hold", bus.D_OUT, w(1, 6, 1));
    put(0, w(0, 7, 0), 1'b1);
    put(1, w(1, 7, 0), 1'b1);
    cyc();
    chk("t6_ptr", rdy, 2'b01);
    drain(20, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
